// File: rtl/sea_pkg.sv
// Shared types and helpers for the iterative 48-bit SEA Feistel controller:
// FSM state encoding, key rotation step, S-box and rotate helpers.
package sea_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int KEY_ROT = 3;

  function automatic logic [2:0] sbox(input logic [2:0] x);
    logic [2:0] y;
    case (x)
      3'd0:    y = 3'd0;
      3'd1:    y = 3'd5;
      3'd2:    y = 3'd6;
      3'd3:    y = 3'd7;
      3'd4:    y = 3'd4;
      3'd5:    y = 3'd3;
      3'd6:    y = 3'd1;
      default: y = 3'd2;
    endcase
    return y;
  endfunction

  function automatic logic [47:0] sbox48(input logic [47:0] x);
    logic [47:0] y;
    y = '0;
    for (int g = 0; g < 16; g++) begin
      y[3*g +: 3] = sbox(x[3*g +: 3]);
    end
    return y;
  endfunction

  // Left rotate by n (mod 48); only ever called with elaboration-time constants.
  function automatic logic [47:0] rotl(input logic [47:0] x, input int n);
    logic [95:0] d;
    d = {x, x} << (n % 48);
    return d[95:48];
  endfunction

endpackage

// File: rtl/sea_round_ctrl_if.sv
// Upstream/downstream valid-ready bundle for sea_round_ctrl.
interface sea_round_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [47:0] in_l;
  logic [47:0] in_r;
  logic [47:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_l;
  logic [47:0] out_r;

  modport master (
    output in_valid, in_decrypt, in_l, in_r, in_key, out_ready,
    input  in_ready, out_valid, out_l, out_r
  );

  modport slave (
    input  in_valid, in_decrypt, in_l, in_r, in_key, out_ready,
    output in_ready, out_valid, out_l, out_r
  );

endinterface

// File: rtl/sea_round.sv
// One combinational SEA Feistel round; the decrypt path is the exact
// inverse of the encrypt path for the same round key.
module sea_round
  import sea_pkg::*;
(
  input  logic [47:0] l,
  input  logic [47:0] r,
  input  logic [47:0] k,
  input  logic        decrypt,
  output logic [47:0] nl,
  output logic [47:0] nr
);

  logic [47:0] fin;
  logic [47:0] fout;

  // The round function always works on the half that passes through unchanged.
  assign fin  = decrypt ? (l ^ k) : (r ^ k);
  assign fout = rotl(sbox48(fin), 1);

  always_comb begin
    nl = r;
    nr = fout ^ {l[7:0], l[47:8]};
    if (decrypt) begin
      nl = rotl(fout ^ r, 8);
      nr = l;
    end
  end

endmodule

// File: rtl/sea_round_ctrl.sv
// Iterative SEA controller: one round per cycle for ROUNDS cycles, key
// generated on the fly, valid/ready handshake on both sides.
module sea_round_ctrl
  import sea_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  sea_round_ctrl_if.slave  bus,
  output logic             busy
);

  // Decrypt starts from the last encrypt key and walks the schedule backwards.
  localparam int          DEC_ROT = (KEY_ROT * (ROUNDS - 1)) % 48;
  localparam logic [5:0]  LAST    = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nx;
  logic [47:0] l_q;
  logic [47:0] r_q;
  logic [47:0] k_q;
  logic        dec_q;
  logic [5:0]  cnt;
  logic [47:0] nl;
  logic [47:0] nr;
  logic        accept;

  sea_round u_round (
    .l       (l_q),
    .r       (r_q),
    .k       (k_q),
    .decrypt (dec_q),
    .nl      (nl),
    .nr      (nr)
  );

  assign accept    = bus.in_valid && bus.in_ready;
  assign bus.out_l = l_q;
  assign bus.out_r = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Data, key and round counter; the result stays in l_q/r_q after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q   <= '0;
      r_q   <= '0;
      k_q   <= '0;
      dec_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            l_q   <= bus.in_l;
            r_q   <= bus.in_r;
            dec_q <= bus.in_decrypt;
            k_q   <= bus.in_decrypt ? rotl(bus.in_key, DEC_ROT) : bus.in_key;
            cnt   <= '0;
          end
        end
        RUN: begin
          l_q <= nl;
          r_q <= nr;
          k_q <= dec_q ? rotl(k_q, 48 - KEY_ROT) : rotl(k_q, KEY_ROT);
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
